// File: rtl/if_rf_skid_stage_if.sv
// Handshake bundle between fetch, the IF/RF elastic stage and decode.
// The master modport is the fetch/decode side; the slave modport is the stage itself.
interface if_rf_skid_stage_if #(
    parameter int PC_W    = 64,
    parameter int INSTR_W = 32
);
    logic               in_valid;
    logic               in_ready;
    logic [PC_W-1:0]    PC_in;
    logic [INSTR_W-1:0] Instruction_in;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [PC_W-1:0]    PC_out;
    logic [INSTR_W-1:0] Instruction_out;
    logic [1:0]         occupancy;

    modport master (
        output in_valid, PC_in, Instruction_in, flush, out_ready,
        input  in_ready, out_valid, PC_out, Instruction_out, occupancy
    );

    modport slave (
        input  in_valid, PC_in, Instruction_in, flush, out_ready,
        output in_ready, out_valid, PC_out, Instruction_out, occupancy
    );
endinterface

// File: rtl/if_rf_skid_stage.sv
// Two-entry elastic IF/RF stage carrying PC + instruction, with registered in_ready,
// synchronous flush and NOP injection whenever decode is not shown a valid entry.
//
// state | meaning
// EMPTY | no entries held; outputs show NOP
// ONE   | main holds the entry presented to decode
// FULL  | main presented, skid holds the next entry; fetch is stalled
module if_rf_skid_stage #(
    parameter int                 PC_W      = 64,
    parameter int                 INSTR_W   = 32,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'hD503201F
) (
    input logic                clk,
    input logic                reset,
    if_rf_skid_stage_if.slave  bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state, state_n;
    logic               in_ready_q;
    logic [PC_W-1:0]    main_pc, skid_pc;
    logic [INSTR_W-1:0] main_instr, skid_instr;
    logic               out_valid;
    logic               in_fire, out_fire;
    logic               ld_main_in, ld_main_skid, ld_skid_in;

    assign out_valid = (state != EMPTY);
    assign in_fire   = bus.in_valid & in_ready_q;
    assign out_fire  = out_valid & bus.out_ready;

    always_comb begin
        state_n      = state;
        ld_main_in   = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid_in   = 1'b0;
        if (bus.flush) begin
            // Anything accepted this cycle is dropped; fetch is redirected anyway.
            state_n = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_n    = ONE;
                        ld_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        ld_main_in = 1'b1;
                    end else if (in_fire) begin
                        state_n    = FULL;
                        ld_skid_in = 1'b1;
                    end else if (out_fire) begin
                        state_n = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_n      = ONE;
                        ld_main_skid = 1'b1;
                    end
                end
                default: state_n = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= EMPTY;
            in_ready_q <= 1'b1;
            main_pc    <= '0;
            main_instr <= '0;
            skid_pc    <= '0;
            skid_instr <= '0;
        end else begin
            state      <= state_n;
            // Computed from next state so fetch never sees a combinational path from decode.
            in_ready_q <= (state_n != FULL);
            if (ld_main_in) begin
                main_pc    <= bus.PC_in;
                main_instr <= bus.Instruction_in;
            end else if (ld_main_skid) begin
                main_pc    <= skid_pc;
                main_instr <= skid_instr;
            end
            if (ld_skid_in) begin
                skid_pc    <= bus.PC_in;
                skid_instr <= bus.Instruction_in;
            end
        end
    end

    assign bus.in_ready        = in_ready_q;
    assign bus.out_valid       = out_valid;
    assign bus.PC_out          = main_pc;
    assign bus.Instruction_out = out_valid ? main_instr : NOP_INSTR;
    assign bus.occupancy       = state;
endmodule

// File: doc/if_rf_skid_stage.md
Name: if_rf_skid_stage

Overview:
- Parametrised successor to the fixed IF/RF pipeline register.
- Sits between fetch and decode and carries PC plus instruction, now as a 2-entry elastic stage with a valid/ready handshake on both sides.
- Supports a synchronous flush for branch redirect, and injects a NOP encoding whenever no valid instruction is presented.
- Decouples decode stalls from fetch without a combinational ready path from decode back to fetch.

Parameters:
- PC_W, 64, width of the PC field.
- INSTR_W, 32, width of the instruction field.
- NOP_INSTR, 32'hD503201F, encoding driven on Instruction_out when out_valid=0 (AArch64 NOP). Width is INSTR_W.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  fetch presents a valid PC/instruction.
- in_ready  output  1  stage can accept; driven directly from a register.
- PC_in  input  PC_W  PC from fetch.
- Instruction_in  input  INSTR_W  instruction from memory.
- flush  input  1  synchronous squash of all held entries.
- out_valid  output  1  decode is presented a valid entry.
- out_ready  input  1  decode accepts the entry this cycle.
- PC_out  output  PC_W  PC into decode.
- Instruction_out  output  INSTR_W  instruction into decode; NOP_INSTR when out_valid=0.
- occupancy  output  2  number of held entries (0..2), for debug and performance counters.

Behaviour:
- Storage and fire conditions:
  - Two entries: main (drives the outputs) and skid.
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- States: EMPTY (0 entries), ONE (main valid), FULL (main + skid valid). out_valid = (state != EMPTY). in_ready = (state != FULL), registered.
- Transitions when flush=0:
  - EMPTY: in_fire -> ONE, main<=in; otherwise stay.
  - ONE: in_fire & out_fire -> ONE, main<=in. in_fire & !out_fire -> FULL, skid<=in. !in_fire & out_fire -> EMPTY. Neither -> hold.
  - FULL: no in_fire is possible. out_fire -> ONE, main<=skid. Otherwise hold.
- Flush:
  - flush=1 has priority over every other event. Next state is EMPTY regardless of in_fire/out_fire.
  - Any entry accepted in the flush cycle is discarded.
  - out_fire in the flush cycle still counts as consumed by decode.
  - Fetch is redirected by the same flush and does not resend the discarded entry.
- Ordering: strict FIFO. The skid entry is never presented before main. No entry is duplicated or lost except by flush.
- Output stability: while out_valid=1 and out_ready=0, PC_out and Instruction_out hold constant.
- Invalid outputs: when out_valid=0, Instruction_out = NOP_INSTR and PC_out holds its last value (0 after reset).
- Latency and throughput:
  - 1 cycle from in_fire to out_valid when the stage was EMPTY or ONE-and-draining.
  - Full throughput of 1 entry per cycle when out_ready is held high.
- Reset (asynchronous, may assert mid-transfer):
  - state=EMPTY, out_valid=0, in_ready=1, occupancy=0, PC_out=0, Instruction_out=NOP_INSTR, skid cleared to 0.
  - Takes effect immediately, without waiting for a clock edge. The first edge after deassertion behaves as EMPTY.
- occupancy = 0/1/2 for EMPTY/ONE/FULL. It updates on the same edge as the state.

Test Plan:
- Reset mid-stream: hold FULL, assert reset between edges -> out_valid=0, in_ready=1, Instruction_out=32'hD503201F, PC_out=0 immediately; occupancy=0.
- Streaming: out_ready=1, feed PC 0x1000,0x1004,0x1008 with instrs 0x91000421,0x91000842,0x91000C63 on consecutive cycles -> each appears one cycle later, in order, occupancy constant 1.
- Backpressure fill: out_ready=0, feed 0x2000 then 0x2004 -> occupancy 2, in_ready=0 on the next cycle, PC_out stays 0x2000. Raise out_ready -> 0x2000 then 0x2004 delivered with no loss or duplication.
- Flush while FULL with in_valid=1 and PC_in=0x3000 -> next cycle out_valid=0, occupancy=0, Instruction_out=NOP, in_ready=1; 0x3000 never appears.
- Simultaneous in/out in ONE: main=0x4000, in=0x4004, out_ready=1 -> next cycle PC_out=0x4004, occupancy=1.
- Parameter sweep: PC_W=32, INSTR_W=16, NOP_INSTR=16'hBF00 -> same sequencing, with the NOP value driven when out_valid=0.
